// File: rtl/rx_ctrl_pkg.sv
// Shared types for the receive frame controller: FSM state encoding,
// error-cause codes and a saturating counter helper.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_CRC     = 3'd1,
    CAUSE_ABORT   = 3'd2,
    CAUSE_NOSLOT  = 3'd3,
    CAUSE_OVERLEN = 3'd4,
    CAUSE_RUNT    = 3'd5
  } err_cause_e;

  localparam int CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Bundle of the deframer inputs, buffer RAM write port, descriptor
// handshake and error counters. slave = controller, master = environment.
interface rx_frame_ctrl_if #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 256
);
  localparam int AW = $clog2(SLOTS * SLOT_BYTES);
  localparam int SW = $clog2(SLOTS);
  localparam int LW = $clog2(SLOT_BYTES) + 1;

  logic          byte_strobe;
  logic [7:0]    byte_data;
  logic          frame_complete;
  logic          frame_valid;
  logic          abort;
  logic          no_clock;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_avail;
  logic [SW-1:0] frame_slot;
  logic [LW-1:0] frame_len;
  logic          frame_ack;
  logic [7:0]    err_crc;
  logic [7:0]    err_abort;
  logic [7:0]    err_drop;

  modport master (
    output byte_strobe, byte_data, frame_complete, frame_valid, abort, no_clock, frame_ack,
    input  wr_en, wr_addr, wr_data, frame_avail, frame_slot, frame_len,
    input  err_crc, err_abort, err_drop
  );

  modport slave (
    input  byte_strobe, byte_data, frame_complete, frame_valid, abort, no_clock, frame_ack,
    output wr_en, wr_addr, wr_data, frame_avail, frame_slot, frame_len,
    output err_crc, err_abort, err_drop
  );

endinterface

// File: rtl/rx_desc_fifo.sv
// Small synchronous FIFO of committed {slot,len} descriptors. The head
// entry is read combinationally so it stays stable while non-empty.
module rx_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Flags, guarded push/pop and pointer advance.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_push   = push && !full;
    do_pop    = pop && !empty;
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_data = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  end

  // Storage write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: allocates a buffer slot per frame, writes the
// bytes, commits good frames to the descriptor FIFO and counts discards.
module rx_frame_ctrl #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 256,
  parameter int MIN_LEN    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  rx_frame_ctrl_if.slave bus
);
  import rx_ctrl_pkg::*;

  localparam int SW = $clog2(SLOTS);
  localparam int OW = $clog2(SLOT_BYTES);
  localparam int LW = OW + 1;
  localparam int AW = SW + OW;

  rx_state_e     state_q, state_d;
  err_cause_e    drop_cause_q, drop_cause_d;
  err_cause_e    cause;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] last_alloc_q, last_alloc_d;
  logic [LW-1:0] len_q, len_d, eff_len;
  logic [SLOTS-1:0] busy_q, busy_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    err_crc_q, err_crc_d, err_abort_q, err_abort_d, err_drop_q, err_drop_d;
  logic          overflow, commit;
  logic          free_found;
  logic [SW-1:0] free_slot, cand;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [SW+LW-1:0] fifo_head;
  logic [SW-1:0] head_slot;

  // Round-robin allocator: first free slot searching from the last allocated one (inclusive).
  always_comb begin
    free_found = 1'b0;
    free_slot  = last_alloc_q;
    cand       = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cand = last_alloc_q + SW'(i);
      if (!free_found && !busy_q[cand]) begin
        free_found = 1'b1;
        free_slot  = cand;
      end
    end
  end

  // FSM next state, byte write generation and per-frame outcome.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    len_d        = len_q;
    last_alloc_d = last_alloc_q;
    drop_cause_d = drop_cause_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cause        = CAUSE_NONE;
    commit       = 1'b0;
    overflow     = 1'b0;
    eff_len      = len_q;
    if (bus.no_clock) begin
      state_d = ST_IDLE;
      if (state_q != ST_IDLE) cause = CAUSE_ABORT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A closing flag or abort arriving with the first byte is treated as idle-line noise.
          if (bus.byte_strobe) begin
            if (free_found) begin
              state_d      = ST_RECV;
              slot_d       = free_slot;
              last_alloc_d = free_slot;
              len_d        = LW'(1);
              wr_en_d      = 1'b1;
              wr_addr_d    = {free_slot, {OW{1'b0}}};
              wr_data_d    = bus.byte_data;
            end else begin
              state_d      = ST_DROP;
              drop_cause_d = CAUSE_NOSLOT;
            end
          end
        end
        ST_RECV: begin
          // A byte arriving with the closing flag is counted before the decision.
          if (bus.byte_strobe) begin
            if (len_q == LW'(SLOT_BYTES)) begin
              overflow = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = {slot_q, len_q[OW-1:0]};
              wr_data_d = bus.byte_data;
              eff_len   = len_q + LW'(1);
            end
          end
          len_d = eff_len;
          if (bus.abort) begin
            state_d = ST_IDLE;
            cause   = CAUSE_ABORT;
          end else if (bus.frame_complete) begin
            state_d = ST_IDLE;
            if (overflow)                       cause  = CAUSE_OVERLEN;
            else if (!bus.frame_valid)          cause  = CAUSE_CRC;
            else if (eff_len < LW'(MIN_LEN))    cause  = CAUSE_RUNT;
            else                                commit = 1'b1;
          end else if (overflow) begin
            state_d      = ST_DROP;
            drop_cause_d = CAUSE_OVERLEN;
          end
        end
        ST_DROP: begin
          if (bus.abort) begin
            state_d = ST_IDLE;
            cause   = CAUSE_ABORT;
          end else if (bus.frame_complete) begin
            state_d = ST_IDLE;
            cause   = drop_cause_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Slot-busy bitmap: set on commit, cleared when the host acks the head descriptor.
  always_comb begin
    head_slot = fifo_head[SW+LW-1:LW];
    fifo_push = commit && !fifo_full;
    fifo_pop  = bus.frame_ack && !fifo_empty;
    busy_d    = busy_q;
    if (fifo_push) busy_d[slot_q] = 1'b1;
    if (fifo_pop)  busy_d[head_slot] = 1'b0;
  end

  // Saturating error counters driven by the per-frame discard cause.
  always_comb begin
    err_crc_d   = (cause == CAUSE_CRC) ? sat_inc(err_crc_q) : err_crc_q;
    err_abort_d = (cause == CAUSE_ABORT) ? sat_inc(err_abort_q) : err_abort_q;
    err_drop_d  = (cause == CAUSE_NOSLOT || cause == CAUSE_OVERLEN || cause == CAUSE_RUNT)
                  ? sat_inc(err_drop_q) : err_drop_q;
  end

  // State, datapath and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      drop_cause_q <= CAUSE_NONE;
      slot_q       <= '0;
      last_alloc_q <= '0;
      len_q        <= '0;
      busy_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_crc_q    <= '0;
      err_abort_q  <= '0;
      err_drop_q   <= '0;
    end else begin
      state_q      <= state_d;
      drop_cause_q <= drop_cause_d;
      slot_q       <= slot_d;
      last_alloc_q <= last_alloc_d;
      len_q        <= len_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_crc_q    <= err_crc_d;
      err_abort_q  <= err_abort_d;
      err_drop_q   <= err_drop_d;
    end
  end

  rx_desc_fifo #(
    .DEPTH(SLOTS),
    .WIDTH(SW + LW)
  ) u_desc_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data({slot_q, eff_len}),
    .pop      (fifo_pop),
    .head_data(fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_avail = !fifo_empty;
  assign bus.frame_slot  = head_slot;
  assign bus.frame_len   = fifo_head[LW-1:0];
  assign bus.err_crc     = err_crc_q;
  assign bus.err_abort   = err_abort_q;
  assign bus.err_drop    = err_drop_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomised scoreboard bench for rx_frame_ctrl: frame-level reference
// model predicts writes, descriptors and counters; monitors compare.
module tb_rx_frame_ctrl;
  localparam int SLOTS      = 4;
  localparam int SLOT_BYTES = 256;
  localparam int MIN_LEN    = 4;

  localparam int E_GOOD  = 0;
  localparam int E_BAD   = 1;
  localparam int E_ABORT = 2;
  localparam int E_NOCLK = 3;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int slot; int len; } desc_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  // Reference model state
  bit    busy_m [SLOTS];
  int    last_alloc_m;
  int    model_q[$];
  int    m_crc, m_abort, m_drop;
  wr_t   exp_wr_q[$];
  desc_t exp_desc_q[$];
  bit    head_checked;

  rx_frame_ctrl_if #(.SLOTS(SLOTS), .SLOT_BYTES(SLOT_BYTES)) bus ();

  rx_frame_ctrl #(.SLOTS(SLOTS), .SLOT_BYTES(SLOT_BYTES), .MIN_LEN(MIN_LEN)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic string end_name(input int e);
    case (e)
      E_GOOD:  return "good";
      E_BAD:   return "crc";
      E_ABORT: return "abort";
      default: return "noclk";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_err_crc"},   bus.err_crc,   m_crc);
    chk({tag, "_err_abort"}, bus.err_abort, m_abort);
    chk({tag, "_err_drop"},  bus.err_drop,  m_drop);
  endtask

  // Host releases the head descriptor; model frees the slot only if one is queued.
  task automatic ack();
    bus.frame_ack = 1'b1;
    if (model_q.size() > 0) busy_m[model_q.pop_front()] = 1'b0;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  // One frame of n bytes with the given ending; the model decides its fate from
  // slot availability, length and ending alone.
  task automatic send_frame(input int n, input int ending, input bit combined,
                            input bit ack_at_end, input bit ramp_data);
    bit   got;
    int   slot;
    bit   comb;
    int   nb;
    logic [7:0] d;
    wr_t  w;
    desc_t ds;
    got  = 1'b0;
    slot = -1;
    for (int i = 0; i < SLOTS; i++) begin
      int s;
      s = (last_alloc_m + i) % SLOTS;
      if (!got && !busy_m[s]) begin
        got  = 1'b1;
        slot = s;
      end
    end
    if (got) last_alloc_m = slot;
    comb = combined && (n >= 2) && (ending == E_GOOD || ending == E_BAD);
    nb   = comb ? n - 1 : n;
    for (int i = 0; i < n; i++) begin
      d = ramp_data ? 8'(i) : 8'($urandom);
      if (got && i < SLOT_BYTES) begin
        w.addr = slot * SLOT_BYTES + i;
        w.data = d;
        exp_wr_q.push_back(w);
      end
      bus.byte_strobe = 1'b1;
      bus.byte_data   = d;
      if (i >= nb) begin
        bus.frame_complete = 1'b1;
        bus.frame_valid    = (ending == E_GOOD);
        if (ack_at_end) bus.frame_ack = 1'b1;
      end else begin
        tick();
        bus.byte_strobe = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
      end
    end
    if (comb) begin
      tick();
    end else begin
      case (ending)
        E_GOOD, E_BAD: begin
          bus.frame_complete = 1'b1;
          bus.frame_valid    = (ending == E_GOOD);
          if (ack_at_end) bus.frame_ack = 1'b1;
          tick();
        end
        E_ABORT: begin
          bus.abort = 1'b1;
          tick();
        end
        default: begin
          bus.no_clock = 1'b1;
          tick();
          tick();
        end
      endcase
    end
    bus.byte_strobe    = 1'b0;
    bus.frame_complete = 1'b0;
    bus.frame_valid    = 1'b0;
    bus.abort          = 1'b0;
    bus.no_clock       = 1'b0;
    bus.frame_ack      = 1'b0;
    if (ack_at_end && (ending == E_GOOD || ending == E_BAD) && model_q.size() > 0)
      busy_m[model_q.pop_front()] = 1'b0;
    if (ending == E_ABORT || ending == E_NOCLK) m_abort = sat(m_abort);
    else if (!got || n > SLOT_BYTES)             m_drop  = sat(m_drop);
    else if (ending == E_BAD)                    m_crc   = sat(m_crc);
    else if (n < MIN_LEN)                        m_drop  = sat(m_drop);
    else begin
      busy_m[slot] = 1'b1;
      model_q.push_back(slot);
      ds.slot = slot;
      ds.len  = n;
      exp_desc_q.push_back(ds);
    end
    $display("frame n=%0d end=%s comb=%0d ack=%0d slot=%0d", n, end_name(ending), comb, ack_at_end, slot);
    tick();
  endtask

  // Write-port monitor: every RAM write must match the next predicted write.
  always @(negedge clk) begin
    if (reset_n && bus.wr_en) begin
      if (exp_wr_q.size() == 0) begin
        chk("wr_unexpected", {bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_wr_q.pop_front();
        chk("wr", {14'd0, bus.wr_addr, bus.wr_data}, 32'((w.addr << 8) | w.data));
      end
    end
  end

  // Descriptor monitor: each new head is compared once; an ack re-arms it.
  always @(negedge clk) begin
    if (!reset_n) begin
      head_checked = 1'b0;
    end else begin
      if (bus.frame_avail && !head_checked) begin
        if (exp_desc_q.size() == 0) begin
          chk("desc_unexpected", {bus.frame_slot, bus.frame_len}, 32'hFFFF_FFFF);
        end else begin
          desc_t ds;
          ds = exp_desc_q.pop_front();
          chk("desc_slot", bus.frame_slot, ds.slot);
          chk("desc_len",  bus.frame_len,  ds.len);
        end
        head_checked = 1'b1;
      end
      if (bus.frame_ack && bus.frame_avail) head_checked = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_alloc_m = 0;
    m_crc = 0; m_abort = 0; m_drop = 0;
    head_checked = 1'b0;
    for (int i = 0; i < SLOTS; i++) busy_m[i] = 1'b0;
    bus.byte_strobe = 1'b0; bus.byte_data = 8'h00; bus.frame_complete = 1'b0;
    bus.frame_valid = 1'b0; bus.abort = 1'b0; bus.no_clock = 1'b0; bus.frame_ack = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_frame_avail", bus.frame_avail, 0);
    chk("rst_frame_slot", bus.frame_slot, 0);
    chk("rst_frame_len", bus.frame_len, 0);
    check_counters("rst");

    // Ramp frame of 10 bytes lands in slot 0 at addresses 0..9.
    send_frame(10, E_GOOD, 1'b0, 1'b0, 1'b1);
    chk("t1_avail", bus.frame_avail, 1);
    ack();
    // Aborted frame, then the next frame reuses slot 0.
    send_frame(6, E_ABORT, 1'b0, 1'b0, 1'b0);
    chk("t2_avail", bus.frame_avail, 0);
    check_counters("t2");
    send_frame(5, E_GOOD, 1'b0, 1'b0, 1'b0);
    ack();

    // Fill every slot; the extra frame is dropped, then an ack frees one slot.
    repeat (5) send_frame(6, E_GOOD, 1'b0, 1'b0, 1'b0);
    check_counters("t3");
    ack();
    send_frame(7, E_GOOD, 1'b0, 1'b0, 1'b0);
    repeat (SLOTS) ack();

    // Over-length and same-cycle byte/complete cases.
    send_frame(257, E_GOOD, 1'b0, 1'b0, 1'b0);
    send_frame(256, E_GOOD, 1'b0, 1'b0, 1'b0);
    send_frame(4, E_GOOD, 1'b1, 1'b0, 1'b0);
    send_frame(4, E_BAD, 1'b1, 1'b0, 1'b0);
    send_frame(3, E_GOOD, 1'b0, 1'b0, 1'b0);
    check_counters("t5");

    // Network clock loss mid-frame, then a commit coinciding with an ack.
    send_frame(5, E_NOCLK, 1'b0, 1'b0, 1'b0);
    check_counters("t6");
    send_frame(8, E_GOOD, 1'b0, 1'b1, 1'b0);
    check_counters("t6b");

    // Random mix of lengths, endings and host acks.
    for (int k = 0; k < 60; k++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 262) : $urandom_range(1, 12);
      send_frame(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 1) == 1) ack();
    end
    check_counters("rand");

    // Enough aborts to saturate the abort counter.
    for (int k = 0; k < 300; k++) send_frame(1, E_ABORT, 1'b0, 1'b0, 1'b0);
    chk("err_abort_sat", bus.err_abort, 255);
    check_counters("sat");

    repeat (SLOTS + 1) ack();
    repeat (3) tick();
    chk("final_avail", bus.frame_avail, 0);
    chk("wr_left", exp_wr_q.size(), 0);
    chk("desc_left", exp_desc_q.size(), 0);
    check_counters("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
